reducer_acc: RTL and testbench
==============================

# reducer_acc

Parametrised reduction stage for the map-reduce user logic. It scans the per-mapper count lanes in round-robin order, one lane per cycle, and combines the valid lanes in one of three modes: saturating sum, max or min. It presents the result on a valid/ready output port together with the contributing-lane count and a sticky overflow flag. It sits between the mapper array and the host-facing register/stream logic, and replaces the free-running fixed-width summer with a start-triggered, handshaked pass.

## Interface
- NUM_MAPPERS, 4: number of input lanes; legal range is 1..1024.
- DATA_WIDTH, 32: width of each lane's count.
- ACC_WIDTH, 40: accumulator and result width; must be at least DATA_WIDTH.
- LCW, $clog2(NUM_MAPPERS+1): width of the lane-count output (derived; not overridden).

Ports (clock and reset first):
- i_clk  input  1  sole clock; all logic is on the rising edge.
- i_rst_n  input  1  reset; synchronous and active-low.
- i_start  input  1  requests a reduction pass; honoured only in IDLE, or in HOLD on the cycle the output handshake completes.
- i_mode  input  2  reduction mode, latched when the start is accepted: 0 = sum, 1 = max, 2 = min, 3 = reserved (treated as sum).
- i_data_count  input  NUM_MAPPERS*DATA_WIDTH  lane k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- i_data_valid  input  NUM_MAPPERS  lane k contributes to the pass only if its bit is 1 on the cycle lane k is scanned.
- o_data_count  output  ACC_WIDTH  result of the pass; stable while o_valid is high.
- o_lane_count  output  LCW  number of lanes that contributed to the pass.
- o_overflow  output  1  set when the sum saturated during the pass.
- o_valid  output  1  the result is available.
- i_ready  input  1  consumer accepts the result.
- o_busy  output  1  high in SCAN and HOLD.

## Operation
- The block has three states: IDLE, SCAN and HOLD. Reset (i_rst_n = 0 at a clock edge) forces IDLE. All outputs reset to 0, and the lane index resets to 0.
- **IDLE**
  - i_start = 1 latches i_mode and sets the lane index to 0.
  - It initialises the accumulator: 0 for sum and max, all-ones for min.
  - It clears the lane count and the overflow flag, then moves to SCAN.
- **SCAN**
  - Each cycle the block processes lane idx.
  - If i_data_valid[idx] = 1:
    - Sum: the accumulator becomes acc + zero-extended data. If the true result exceeds 2^ACC_WIDTH-1, it saturates to all-ones and the overflow flag is set.
    - Max: the accumulator becomes max(acc, data).
    - Min: the accumulator becomes min(acc, data).
    - The lane count increments.
  - Invalid lanes are skipped; they still take one cycle.
  - idx increments every cycle. After lane NUM_MAPPERS-1 is processed, the block moves to HOLD. Exactly NUM_MAPPERS SCAN cycles occur per pass, with no extra cycle.
- **On entering HOLD**
  - o_data_count is loaded from the final accumulator, with one exception: if the lane count is 0, the result is 0 in every mode, so min mode does not output all-ones.
  - o_lane_count and o_overflow are loaded, and o_valid rises.
- **HOLD**
  - The result registers stay frozen until i_ready = 1 while o_valid = 1.
  - On that handshake edge, o_valid falls and the block returns to IDLE.
  - If i_start = 1 on the same edge, the block instead goes directly to SCAN with a fresh pass (back-to-back mode).
- i_start is ignored in SCAN, and in HOLD without i_ready.
- i_mode is ignored except on an accepted start.
- Changes to i_data_count or i_data_valid on lanes already scanned do not affect the current pass.
- o_data_count, o_lane_count and o_overflow hold their last values after the handshake, until the next pass completes.

## Timing
- Start accepted at edge T: SCAN runs on edges T+1 .. T+NUM_MAPPERS, and o_valid is high from edge T+NUM_MAPPERS+1. Latency is NUM_MAPPERS+1 cycles.
- o_busy goes high at edge T+1 and falls on the handshake edge, unless a back-to-back start keeps it high.
- Minimum pass interval is NUM_MAPPERS+1 cycles, achieved with i_ready and i_start held high.
- With NUM_MAPPERS = 1, SCAN lasts a single cycle.
- Reset asserted mid-SCAN or in HOLD takes effect at that edge: the pass is discarded, and no o_valid is produced for it.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- **Sum, all lanes valid.** NUM_MAPPERS = 4, lanes = 10, 20, 30, 40, start at T -> o_valid at T+5 with o_data_count = 100, o_lane_count = 4, o_overflow = 0.
- **Lane skipping and min mode.**
  - Valid = 4'b1010, lanes = 5, 7, 9, 3, mode min -> result 3, lane count 2.
  - Mode max with the same inputs -> result 7.
- **Saturation.** DATA_WIDTH = 32, ACC_WIDTH = 33, four lanes of 0xFFFF_FFFF -> result 0x1_FFFF_FFFF, o_overflow = 1.
- **No valid lanes.** Valid = 0, mode min -> result 0, lane count 0, o_valid still asserted after 5 cycles.
- **Backpressure and back-to-back passes.**
  - Hold i_ready = 0 for 10 cycles -> the result is unchanged and o_valid stays high.
  - Pulse i_start while in SCAN -> ignored.
  - Assert i_ready and i_start together -> the next o_valid arrives exactly 5 cycles later, with the new mode applied.
- **Reset mid-pass.** i_rst_n = 0 during the second SCAN cycle -> all outputs read 0 and the state is IDLE. A new start then produces a correct result with no residue from the aborted pass.

Source files
------------

// File: rtl/reducer_acc.sv
// Start-triggered reduction stage: scans mapper lanes round-robin, one per cycle,
// combining valid lanes by saturating sum, max or min, and hands the result out on valid/ready.
`timescale 1ns/1ps

module reducer_acc #(
    parameter int NUM_MAPPERS = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int ACC_WIDTH   = 40,
    localparam int LCW        = $clog2(NUM_MAPPERS + 1)
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic                              i_start,
    input  logic [1:0]                        i_mode,
    input  logic [NUM_MAPPERS*DATA_WIDTH-1:0] i_data_count,
    input  logic [NUM_MAPPERS-1:0]            i_data_valid,
    output logic [ACC_WIDTH-1:0]              o_data_count,
    output logic [LCW-1:0]                    o_lane_count,
    output logic                              o_overflow,
    output logic                              o_valid,
    input  logic                              i_ready,
    output logic                              o_busy
);

    localparam int IDX_W = (NUM_MAPPERS > 1) ? $clog2(NUM_MAPPERS) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic [1:0] MODE_MAX = 2'd1;
    localparam logic [1:0] MODE_MIN = 2'd2;

    logic [1:0]           state;
    logic [1:0]           mode_q;
    logic [IDX_W-1:0]     idx;
    logic [ACC_WIDTH-1:0] acc;
    logic [LCW-1:0]       lane_cnt;
    logic                 ovf;

    logic [DATA_WIDTH-1:0] lane_data;
    logic                  lane_valid;
    logic [ACC_WIDTH-1:0]  data_ext;
    logic [ACC_WIDTH:0]    sum_full;
    logic [ACC_WIDTH-1:0]  acc_step;
    logic [LCW-1:0]        cnt_step;
    logic                  ovf_step;
    logic                  last_lane;
    logic                  start_ok;
    logic [ACC_WIDTH-1:0]  acc_init;

    // Lane select as an explicit mux so the index never reaches past the last lane.
    always_comb begin
        lane_data  = '0;
        lane_valid = 1'b0;
        for (int k = 0; k < NUM_MAPPERS; k++) begin
            if (idx == IDX_W'(k)) begin
                lane_data  = i_data_count[k*DATA_WIDTH +: DATA_WIDTH];
                lane_valid = i_data_valid[k];
            end
        end
    end

    assign data_ext  = ACC_WIDTH'(lane_data);
    assign sum_full  = {1'b0, acc} + {1'b0, data_ext};
    assign last_lane = (idx == IDX_W'(NUM_MAPPERS - 1));
    assign start_ok  = i_start && ((state == ST_IDLE) || ((state == ST_HOLD) && i_ready));
    assign acc_init  = (i_mode == MODE_MIN) ? '1 : '0;

    always_comb begin
        acc_step = acc;
        cnt_step = lane_cnt;
        ovf_step = ovf;
        if (lane_valid) begin
            cnt_step = lane_cnt + LCW'(1);
            case (mode_q)
                MODE_MAX: if (data_ext > acc) acc_step = data_ext;
                MODE_MIN: if (data_ext < acc) acc_step = data_ext;
                default: begin
                    // Reserved mode 3 falls here and behaves as a sum.
                    if (sum_full[ACC_WIDTH]) begin
                        acc_step = '1;
                        ovf_step = 1'b1;
                    end else begin
                        acc_step = sum_full[ACC_WIDTH-1:0];
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            mode_q   <= '0;
            idx      <= '0;
            acc      <= '0;
            lane_cnt <= '0;
            ovf      <= 1'b0;
        end else if (start_ok) begin
            mode_q   <= i_mode;
            idx      <= '0;
            acc      <= acc_init;
            lane_cnt <= '0;
            ovf      <= 1'b0;
        end else if (state == ST_SCAN) begin
            acc      <= acc_step;
            lane_cnt <= cnt_step;
            ovf      <= ovf_step;
            idx      <= last_lane ? '0 : idx + IDX_W'(1);
        end
    end

    // Result registers load only on the final scan edge and otherwise hold,
    // including across the handshake, until the next pass completes.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state        <= ST_IDLE;
            o_data_count <= '0;
            o_lane_count <= '0;
            o_overflow   <= 1'b0;
            o_valid      <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        state  <= ST_SCAN;
                        o_busy <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (last_lane) begin
                        state        <= ST_HOLD;
                        o_data_count <= (cnt_step == '0) ? '0 : acc_step;
                        o_lane_count <= cnt_step;
                        o_overflow   <= ovf_step;
                        o_valid      <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        if (i_start) begin
                            state <= ST_SCAN;
                        end else begin
                            state  <= ST_IDLE;
                            o_busy <= 1'b0;
                        end
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reducer_acc.sv
// Scoreboard bench for reducer_acc: expected results are queued at each start
// and compared when o_valid appears; a narrow-accumulator copy covers saturation.
`timescale 1ns/1ps

module tb_reducer_acc;

    localparam int N      = 4;
    localparam int DW     = 32;
    localparam int AW     = 40;
    localparam int AW_SAT = 33;
    localparam int LCW    = $clog2(N + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              start;
    logic              ready;
    logic [1:0]        mode;
    logic [N*DW-1:0]   data;
    logic [N-1:0]      valid;

    logic [AW-1:0]     o_data;
    logic [LCW-1:0]    o_lanes;
    logic              o_ovf;
    logic              o_valid;
    logic              o_busy;

    logic [AW_SAT-1:0] s_data;
    logic [LCW-1:0]    s_lanes;
    logic              s_ovf;
    logic              s_valid;
    logic              s_busy;

    reducer_acc #(.NUM_MAPPERS(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_mode(mode),
        .i_data_count(data), .i_data_valid(valid),
        .o_data_count(o_data), .o_lane_count(o_lanes), .o_overflow(o_ovf),
        .o_valid(o_valid), .i_ready(ready), .o_busy(o_busy)
    );

    reducer_acc #(.NUM_MAPPERS(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW_SAT)) dut_sat (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_mode(mode),
        .i_data_count(data), .i_data_valid(valid),
        .o_data_count(s_data), .o_lane_count(s_lanes), .o_overflow(s_ovf),
        .o_valid(s_valid), .i_ready(ready), .o_busy(s_busy)
    );

    typedef struct {
        logic [63:0] res;
        logic [63:0] lanes;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;
    int   accept_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic [1:0] m, input logic [N*DW-1:0] d,
                                   input logic [N-1:0] v, input int aw);
        exp_t        r;
        logic [63:0] maxv;
        logic [63:0] acc;
        logic [63:0] x;
        int          cnt;
        maxv  = (64'd1 << aw) - 64'd1;
        acc   = (m == 2'd2) ? maxv : 64'd0;
        cnt   = 0;
        r.ovf = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (v[k]) begin
                x = 64'(d[k*DW +: DW]);
                cnt++;
                case (m)
                    2'd1: if (x > acc) acc = x;
                    2'd2: if (x < acc) acc = x;
                    default: begin
                        if (acc + x > maxv) begin
                            acc   = maxv;
                            r.ovf = 1'b1;
                        end else begin
                            acc = acc + x;
                        end
                    end
                endcase
            end
        end
        r.res   = (cnt == 0) ? 64'd0 : acc;
        r.lanes = 64'(cnt);
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want)
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        else
            passes++;
    endtask

    // Drive one start (optionally with ready for a back-to-back handshake) and queue its expectation.
    task automatic applyStimulus(input logic [1:0] m, input logic [N*DW-1:0] d,
                                 input logic [N-1:0] v, input logic with_ready);
        mode  = m;
        data  = d;
        valid = v;
        start = 1'b1;
        ready = with_ready;
        sb.push_back(model(m, d, v, AW));
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        start = 1'b0;
        ready = 1'b0;
    endtask

    task automatic waitResult(input string tag);
        exp_t e;
        bit   seen;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (o_valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checkOutput({tag, "_timeout"}, 64'd0, 64'd1);
        end else if (sb.size() == 0) begin
            checkOutput({tag, "_sb_empty"}, 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            checkOutput({tag, "_data"}, 64'(o_data), e.res);
            checkOutput({tag, "_lanes"}, 64'(o_lanes), e.lanes);
            checkOutput({tag, "_ovf"}, 64'(o_ovf), 64'(e.ovf));
            checkOutput({tag, "_latency"}, 64'(cyc - accept_cyc + 1), 64'd5);
        end
    endtask

    task automatic handshake(input string tag);
        ready = 1'b1;
        @(posedge clk);
        #1;
        ready = 1'b0;
        checkOutput({tag, "_valid_drop"}, 64'(o_valid), 64'd0);
        checkOutput({tag, "_busy_drop"}, 64'(o_busy), 64'd0);
    endtask

    logic [N*DW-1:0] d_tmp;
    logic [63:0]     held;
    exp_t            e_sat;
    bit              stable;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        ready = 1'b0;
        mode  = 2'd0;
        data  = '0;
        valid = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_valid", 64'(o_valid), 64'd0);
        checkOutput("rst_busy", 64'(o_busy), 64'd0);
        checkOutput("rst_data", 64'(o_data), 64'd0);
        checkOutput("rst_lanes", 64'(o_lanes), 64'd0);
        checkOutput("rst_ovf", 64'(o_ovf), 64'd0);
        checkOutput("rst_sat_valid", 64'(s_valid), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Sum over all lanes, then backpressure with a start pulse that must be ignored.
        applyStimulus(2'd0, {32'd40, 32'd30, 32'd20, 32'd10}, 4'b1111, 1'b0);
        checkOutput("sum_busy", 64'(o_busy), 64'd1);
        waitResult("sum");
        held   = 64'(o_data);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            start = (i == 3);
            @(negedge clk);
            if (!o_valid || 64'(o_data) != held) stable = 1'b0;
        end
        start = 1'b0;
        checkOutput("hold_stable", 64'(stable), 64'd1);
        checkOutput("hold_data", 64'(o_data), 64'd100);
        handshake("sum");
        checkOutput("sum_data_kept", 64'(o_data), 64'd100);

        // Min with skipped lanes; a start/mode change during the scan must not disturb it.
        applyStimulus(2'd2, {32'd3, 32'd9, 32'd7, 32'd5}, 4'b1010, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b1;
        mode  = 2'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitResult("min");
        handshake("min");

        // Max on the same lanes, then a back-to-back pass in reserved mode 3 (sum).
        applyStimulus(2'd1, {32'd3, 32'd9, 32'd7, 32'd5}, 4'b1010, 1'b0);
        waitResult("max");
        applyStimulus(2'd3, {32'd4, 32'd3, 32'd2, 32'd1}, 4'b0111, 1'b1);
        checkOutput("b2b_valid_drop", 64'(o_valid), 64'd0);
        checkOutput("b2b_busy_kept", 64'(o_busy), 64'd1);
        waitResult("b2b");
        handshake("b2b");

        // Saturation: the 33-bit copy clips, the 40-bit copy does not.
        d_tmp = {N{32'hFFFF_FFFF}};
        applyStimulus(2'd0, d_tmp, 4'b1111, 1'b0);
        e_sat = model(2'd0, d_tmp, 4'b1111, AW_SAT);
        waitResult("sat_wide");
        checkOutput("sat_valid", 64'(s_valid), 64'd1);
        checkOutput("sat_data", 64'(s_data), e_sat.res);
        checkOutput("sat_ovf", 64'(s_ovf), 64'(e_sat.ovf));
        checkOutput("sat_lanes", 64'(s_lanes), e_sat.lanes);
        handshake("sat");

        // No valid lanes in min mode must report zero, not all-ones.
        applyStimulus(2'd2, {32'd8, 32'd6, 32'd4, 32'd2}, 4'b0000, 1'b0);
        waitResult("none");
        handshake("none");

        // Reset during the second scan cycle discards the pass entirely.
        applyStimulus(2'd0, {32'd900, 32'd800, 32'd700, 32'd600}, 4'b1111, 1'b0);
        sb.delete(sb.size() - 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput("midrst_valid", 64'(o_valid), 64'd0);
        checkOutput("midrst_busy", 64'(o_busy), 64'd0);
        checkOutput("midrst_data", 64'(o_data), 64'd0);
        checkOutput("midrst_lanes", 64'(o_lanes), 64'd0);
        checkOutput("midrst_ovf", 64'(o_ovf), 64'd0);
        stable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (o_valid || o_busy) stable = 1'b0;
        end
        checkOutput("midrst_quiet", 64'(stable), 64'd1);

        // Fresh pass after the abort; lane 0 changes after it was scanned and must not matter.
        @(posedge clk);
        #1;
        applyStimulus(2'd0, {32'd8, 32'd7, 32'd6, 32'd5}, 4'b1111, 1'b0);
        @(posedge clk);
        #1;
        data[DW-1:0] = 32'd1000;
        waitResult("recover");
        handshake("recover");

        checkOutput("sb_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
